// File: rtl/dev_latch_port_ctrl.sv
// dev_latch_port_ctrl: decodes CPU OUT cycles onto per-device latches and queues each update
// to the mapper through a first-word-fall-through FIFO, holding the CPU when the queue is full.
module dev_latch_port_ctrl #(
  parameter int          NUM_DEV    = 3,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  RESET_VAL  = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   io_wr,
  input  logic [7:0]             io_addr,
  input  logic [7:0]             io_data,
  input  logic [NUM_DEV-1:0]     dev_en,
  input  logic [8*NUM_DEV-1:0]   dev_port,
  input  logic [8*NUM_DEV-1:0]   dev_mask,
  input  logic [1:0]             sel_dev,
  output logic                   cpu_wait,
  output logic                   upd_valid,
  input  logic                   upd_ready,
  output logic [1:0]             upd_dev,
  output logic [7:0]             upd_data,
  output logic [7:0]             data_to_mapper
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, PUSH, STALL} state_t;
  state_t         state_q, state_d;
  logic           io_wr_q;
  logic           cpu_wait_q, cpu_wait_d;
  logic [7:0]     latch_q [NUM_DEV];
  logic [7:0]     latch_d [NUM_DEV];
  logic [1:0]     cap_dev_q, cap_dev_d;
  logic [7:0]     cap_data_q, cap_data_d;
  logic [9:0]     mem_q [FIFO_DEPTH];
  logic [9:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           wr_edge, hit, push, pop, full;
  logic [1:0]     win;
  assign wr_edge   = io_wr & ~io_wr_q;
  assign full      = count_q == CW'(FIFO_DEPTH);
  assign upd_valid = count_q != '0;
  assign pop       = upd_valid & upd_ready;
  assign upd_dev   = upd_valid ? mem_q[rptr_q][9:8] : '0;
  assign upd_data  = upd_valid ? mem_q[rptr_q][7:0] : '0;
  assign cpu_wait  = cpu_wait_q;
  // descending scan so the lowest matching index is the one left standing
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--)
      if (dev_en[i] && ((io_addr & dev_mask[8*i +: 8]) == (dev_port[8*i +: 8] & dev_mask[8*i +: 8]))) begin
        hit = 1'b1;
        win = 2'(i);
      end
  end
  always_comb begin
    data_to_mapper = RESET_VAL;
    for (int i = 0; i < NUM_DEV; i++)
      if (sel_dev == 2'(i)) data_to_mapper = latch_q[i];
  end
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    latch_d    = latch_q;
    cap_dev_d  = cap_dev_q;
    cap_data_d = cap_data_q;
    if (state_q == IDLE) begin
      if (wr_edge && hit) begin
        for (int i = 0; i < NUM_DEV; i++)
          if (win == 2'(i)) latch_d[i] = io_data;
        cap_dev_d  = win;
        cap_data_d = io_data;
        state_d    = PUSH;
      end
    end else begin
      push    = !full || pop;
      state_d = push ? IDLE : STALL;
    end
    cpu_wait_d = state_d == STALL;
  end
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr_q] = {cap_dev_q, cap_data_q};
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      io_wr_q    <= 1'b0;
      cpu_wait_q <= 1'b0;
      latch_q    <= '{default: RESET_VAL};
      cap_dev_q  <= '0;
      cap_data_q <= '0;
      mem_q      <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      io_wr_q    <= io_wr;
      cpu_wait_q <= cpu_wait_d;
      latch_q    <= latch_d;
      cap_dev_q  <= cap_dev_d;
      cap_data_q <= cap_data_d;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end
endmodule

// File: tb/tb_dev_latch_port_ctrl.sv
// tb_dev_latch_port_ctrl: scenario tasks drive OUT cycles and queue the updates the mapper
// should see; a negedge monitor pops and compares each accepted FIFO beat.
module tb_dev_latch_port_ctrl;
  logic        clk = 1'b0;
  logic        reset_n, io_wr, upd_ready, cpu_wait, upd_valid;
  logic [7:0]  io_addr, io_data, upd_data, data_to_mapper;
  logic [2:0]  dev_en;
  logic [23:0] dev_port, dev_mask;
  logic [1:0]  sel_dev, upd_dev;
  logic [9:0]  exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          beats  = 0;

  dev_latch_port_ctrl dut (
    .clk(clk), .reset_n(reset_n), .io_wr(io_wr), .io_addr(io_addr), .io_data(io_data),
    .dev_en(dev_en), .dev_port(dev_port), .dev_mask(dev_mask), .sel_dev(sel_dev),
    .cpu_wait(cpu_wait), .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_dev(upd_dev),
    .upd_data(upd_data), .data_to_mapper(data_to_mapper)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && upd_valid && upd_ready) begin
      logic [9:0] e;
      beats++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got dev=%0d data=%h, none expected", upd_dev, upd_data);
      end else begin
        e = exp_q.pop_front();
        if ({upd_dev, upd_data} !== e) begin
          errors++;
          $display("FAIL beat got dev=%0d data=%h, expected dev=%0d data=%h", upd_dev, upd_data, e[9:8], e[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit exp_hit, input logic [1:0] dv);
    io_addr = a;
    io_data = d;
    io_wr   = 1'b1;
    if (exp_hit) exp_q.push_back({dv, d});
    tick();
    tick();
    io_wr = 1'b0;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain %0d entries still pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks += 5;
    if (data_to_mapper !== 8'hFF) begin errors++; $display("FAIL reset_dtm got %h exp ff", data_to_mapper); end
    if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", upd_valid); end
    if (cpu_wait !== 1'b0) begin errors++; $display("FAIL reset_wait got %b exp 0", cpu_wait); end
    if ({upd_dev, upd_data} !== 10'd0) begin errors++; $display("FAIL reset_head got %h exp 0", {upd_dev, upd_data}); end
    sel_dev = 2'd3;
    #1;
    if (data_to_mapper !== 8'hFF) begin errors++; $display("FAIL reset_sel3 got %h exp ff", data_to_mapper); end
    sel_dev = 2'd0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int b0;
    dev_en   = 3'b001;
    dev_port = {8'h00, 8'h00, 8'hFE};
    dev_mask = {8'h00, 8'h00, 8'hFF};
    upd_ready = 1'b1;
    b0 = beats;
    io_addr = 8'hFE;
    io_data = 8'h35;
    io_wr   = 1'b1;
    exp_q.push_back({2'd0, 8'h35});
    checks++;
    if (data_to_mapper !== 8'hFF) begin errors++; $display("FAIL basic_n got %h exp ff", data_to_mapper); end
    tick();
    checks += 2;
    if (data_to_mapper !== 8'h35) begin errors++; $display("FAIL basic_n1_latch got %h exp 35", data_to_mapper); end
    if (upd_valid !== 1'b0) begin errors++; $display("FAIL basic_n1_valid got %b exp 0", upd_valid); end
    tick();
    checks++;
    if ({upd_valid, upd_dev, upd_data} !== {1'b1, 2'd0, 8'h35}) begin
      errors++;
      $display("FAIL basic_n2_head got v=%b dev=%0d data=%h exp v=1 dev=0 data=35", upd_valid, upd_dev, upd_data);
    end
    tick();
    tick();
    io_wr = 1'b0;
    tick();
    tick();
    checks += 2;
    if (upd_valid !== 1'b0) begin errors++; $display("FAIL basic_after_valid got %b exp 0", upd_valid); end
    if (beats - b0 !== 1) begin errors++; $display("FAIL basic_beats got %0d exp 1", beats - b0); end
  endtask

  task automatic test_priority();
    dev_en   = 3'b011;
    dev_port = {8'h00, 8'h9A, 8'h90};
    dev_mask = {8'h00, 8'hFF, 8'hF0};
    do_write(8'h9A, 8'h11, 1'b1, 2'd0);
    drain();
    sel_dev = 2'd0;
    #1;
    checks++;
    if (data_to_mapper !== 8'h11) begin errors++; $display("FAIL prio_latch0 got %h exp 11", data_to_mapper); end
    sel_dev = 2'd1;
    #1;
    checks++;
    if (data_to_mapper !== 8'hFF) begin errors++; $display("FAIL prio_latch1 got %h exp ff", data_to_mapper); end
    do_write(8'h7A, 8'h22, 1'b0, 2'd0);
    tick();
    checks += 2;
    if (upd_valid !== 1'b0) begin errors++; $display("FAIL nohit_valid got %b exp 0", upd_valid); end
    if (data_to_mapper !== 8'hFF) begin errors++; $display("FAIL nohit_latch1 got %h exp ff", data_to_mapper); end
    sel_dev = 2'd0;
    #1;
    checks++;
    if (data_to_mapper !== 8'h11) begin errors++; $display("FAIL nohit_latch0 got %h exp 11", data_to_mapper); end
  endtask

  task automatic test_stall();
    dev_en    = 3'b010;
    upd_ready = 1'b0;
    sel_dev   = 2'd1;
    for (int i = 1; i <= 4; i++) do_write(8'h9A, 8'(i), 1'b1, 2'd1);
    checks++;
    if (cpu_wait !== 1'b0) begin errors++; $display("FAIL stall_early_wait got %b exp 0", cpu_wait); end
    io_data = 8'h05;
    io_wr   = 1'b1;
    exp_q.push_back({2'd1, 8'h05});
    tick();
    tick();
    checks++;
    if (cpu_wait !== 1'b1) begin errors++; $display("FAIL stall_wait got %b exp 1", cpu_wait); end
    io_wr = 1'b0;
    tick();
    io_data = 8'h77;
    io_wr   = 1'b1;
    tick();
    io_wr = 1'b0;
    tick();
    checks += 3;
    if (cpu_wait !== 1'b1) begin errors++; $display("FAIL stall_hold_wait got %b exp 1", cpu_wait); end
    if (data_to_mapper !== 8'h05) begin errors++; $display("FAIL stall_latch got %h exp 05", data_to_mapper); end
    if ({upd_dev, upd_data} !== {2'd1, 8'h01}) begin errors++; $display("FAIL stall_head_stable got %h exp 101", {upd_dev, upd_data}); end
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
    checks += 2;
    if (cpu_wait !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", cpu_wait); end
    if (upd_data !== 8'h02) begin errors++; $display("FAIL stall_next_head got %h exp 02", upd_data); end
    upd_ready = 1'b1;
    drain();
    tick();
    checks++;
    if (upd_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got %b exp 0", upd_valid); end
  endtask

  task automatic test_full_pop();
    upd_ready = 1'b0;
    for (int i = 1; i <= 4; i++) do_write(8'h9A, 8'hA0 + 8'(i), 1'b1, 2'd1);
    io_data = 8'hA5;
    io_wr   = 1'b1;
    exp_q.push_back({2'd1, 8'hA5});
    tick();
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
    checks += 2;
    if (cpu_wait !== 1'b0) begin errors++; $display("FAIL fullpop_wait got %b exp 0", cpu_wait); end
    if (upd_data !== 8'hA2) begin errors++; $display("FAIL fullpop_head got %h exp a2", upd_data); end
    io_wr = 1'b0;
    tick();
    checks++;
    if (cpu_wait !== 1'b0) begin errors++; $display("FAIL fullpop_wait2 got %b exp 0", cpu_wait); end
    io_data = 8'hA6;
    io_wr   = 1'b1;
    exp_q.push_back({2'd1, 8'hA6});
    tick();
    tick();
    checks++;
    if (cpu_wait !== 1'b1) begin errors++; $display("FAIL fullpop_count4_stall got %b exp 1", cpu_wait); end
    io_wr = 1'b0;
    tick();
  endtask

  task automatic test_reset_stall();
    reset_n = 1'b0;
    exp_q.delete();
    tick();
    tick();
    checks += 2;
    if (upd_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_valid got %b exp 0", upd_valid); end
    if (cpu_wait !== 1'b0) begin errors++; $display("FAIL rst_stall_wait got %b exp 0", cpu_wait); end
    for (int i = 0; i < 3; i++) begin
      sel_dev = 2'(i);
      #1;
      checks++;
      if (data_to_mapper !== 8'hFF) begin errors++; $display("FAIL rst_stall_latch%0d got %h exp ff", i, data_to_mapper); end
    end
    reset_n   = 1'b1;
    upd_ready = 1'b1;
    tick();
    tick();
    tick();
    checks += 2;
    if (upd_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_after_valid got %b exp 0", upd_valid); end
    if (cpu_wait !== 1'b0) begin errors++; $display("FAIL rst_stall_after_wait got %b exp 0", cpu_wait); end
  endtask

  initial begin
    reset_n = 1'b0; io_wr = 1'b0; io_addr = '0; io_data = '0; upd_ready = 1'b0;
    dev_en = '0; dev_port = '0; dev_mask = '0; sel_dev = '0;
    test_reset();
    test_basic();
    test_priority();
    test_stall();
    test_full_pop();
    test_reset_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
